// File: rtl/fifo_push_arbiter.sv
//============================================================================
// Module   : fifo_push_arbiter
// Brief    : round-robin, burst-locking arbiter sharing one SyncFIFO push port
// Revision : 1.0
//============================================================================
`default_nettype none

module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_payload_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_push_o,
    output logic [WORD_WIDTH-1:0]         fifo_push_payload_o,
    output logic [ID_WIDTH-1:0]           fifo_push_src_o,
    input  logic                          fifo_full_i,
    input  logic                          flush_i,
    output logic                          fifo_flush_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          locked_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
    logic [ID_WIDTH-1:0] owner_q,    owner_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic [ID_WIDTH-1:0]   arb_win;
    logic                  arb_found;
    logic [ID_WIDTH-1:0]   win;
    logic                  win_valid;
    logic                  acc;
    logic [WORD_WIDTH-1:0] win_payload;

    // Increment modulo NUM_REQ without ever forming an out-of-range index.
    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        if (id == ID_WIDTH'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr_q.
    always_comb begin : p_rr_search
        int idx;
        idx       = 0;
        arb_win   = '0;
        arb_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_found && req_valid_i[ID_WIDTH'(idx)]) begin
                arb_found = 1'b1;
                arb_win   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin : p_winner
        if (state_q == ST_LOCK) begin
            win       = owner_q;
            win_valid = 1'b1;
        end else begin
            win       = arb_win;
            win_valid = arb_found;
        end
        acc = win_valid & req_valid_i[win] & ~fifo_full_i & ~flush_i;
    end

    always_comb begin : p_payload_mux
        win_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_WIDTH'(i)) begin
                win_payload = req_payload_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : p_state_reg
        if (!rstn) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin : p_next_state
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (flush_i) begin
            // An abandoned lock still passes the turn to the next requester.
            state_d    = ST_ARB;
            beat_cnt_d = '0;
            if (state_q == ST_LOCK) begin
                rr_ptr_d = next_id(owner_q);
            end
        end else if (acc) begin
            case (state_q)
                ST_ARB: begin
                    if (req_last_i[win] || (MAX_BURST == 1)) begin
                        rr_ptr_d   = next_id(win);
                        beat_cnt_d = '0;
                    end else begin
                        state_d    = ST_LOCK;
                        owner_d    = win;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (req_last_i[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d    = ST_ARB;
                        rr_ptr_d   = next_id(owner_q);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_ARB;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin : p_outputs
        grant_o             = win_valid ? (NUM_REQ'(1) << win) : '0;
        req_ready_o         = acc ? (NUM_REQ'(1) << win) : '0;
        fifo_push_o         = acc;
        fifo_push_payload_o = acc ? win_payload : '0;
        fifo_push_src_o     = acc ? win : '0;
        fifo_flush_o        = flush_i;
        locked_o            = (state_q == ST_LOCK);
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_o));
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready_o));
    a_push_not_full : assert property (@(posedge clk) disable iff (!rstn) fifo_push_o |-> !fifo_full_i);
    a_push_is_ready : assert property (@(posedge clk) disable iff (!rstn) fifo_push_o == (|req_ready_o));

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
//============================================================================
// Module   : tb_fifo_push_arbiter
// Brief    : directed and randomized self-checking bench for fifo_push_arbiter
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int WW = 32;
    localparam int MB = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    valid;
    logic [NR-1:0]    last;
    logic [NR*WW-1:0] payload;
    logic             full;
    logic             flush;
    logic [NR-1:0]    ready;
    logic             push;
    logic [WW-1:0]    ppay;
    logic [IW-1:0]    psrc;
    logic             fflush;
    logic [NR-1:0]    grant;
    logic             locked;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_push_arbiter #(
        .NUM_REQ    (NR),
        .WORD_WIDTH (WW),
        .MAX_BURST  (MB),
        .ID_WIDTH   (IW)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .req_valid_i         (valid),
        .req_last_i          (last),
        .req_payload_i       (payload),
        .req_ready_o         (ready),
        .fifo_push_o         (push),
        .fifo_push_payload_o (ppay),
        .fifo_push_src_o     (psrc),
        .fifo_full_i         (full),
        .flush_i             (flush),
        .fifo_flush_o        (fflush),
        .grant_o             (grant),
        .locked_o            (locked)
    );

    always #5 clk = ~clk;

    task automatic randomize_payloads();
        for (int i = 0; i < NR; i++) payload[i*WW +: WW] = $urandom;
    endtask

    task automatic do_reset();
        rstn = 1'b0; valid = '0; last = '0; payload = '0; full = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0 || ready !== 4'b0 || push !== 1'b0 || locked !== 1'b0 ||
            psrc !== 2'd0 || ppay !== 32'd0 || fflush !== 1'b0) begin
            $display("FAIL reset_outputs: grant=%b ready=%b push=%b locked=%b src=%0d pay=%h flush_o=%b, required all zero",
                     grant, ready, push, locked, psrc, ppay, fflush);
            n_fail++;
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (fflush !== 1'b1 || push !== 1'b0) begin
            $display("FAIL reset_flush_follow: flush_o=%b push=%b, required 1 0", fflush, push);
            n_fail++;
        end
        flush = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        valid = 4'b0010; last = 4'b0000; randomize_payloads();
        @(negedge clk);
        #1;
        n_checks++;
        if (locked !== 1'b1) begin
            $display("FAIL reset_prelock: locked=%b, required 1", locked);
            n_fail++;
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (locked !== 1'b0) begin
            $display("FAIL reset_async: locked=%b, required 0", locked);
            n_fail++;
        end
        valid = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_fair_rotation();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            valid = 4'hF; last = 4'hF; randomize_payloads();
            #1;
            n_checks++;
            if (push !== 1'b1 || psrc !== IW'(c % NR) || ready !== (4'b0001 << (c % NR)) ||
                ppay !== payload[(c % NR)*WW +: WW]) begin
                $display("FAIL rotation c%0d: push=%b src=%0d ready=%b pay=%h, required push=1 src=%0d pay=%h",
                         c, push, psrc, ready, ppay, c % NR, payload[(c % NR)*WW +: WW]);
                n_fail++;
            end
        end
    endtask

    task automatic test_burst_lock();
        int exp_src [7] = '{1, 1, 1, 1, 2, 1, 1};
        bit exp_lck [7] = '{0, 1, 1, 1, 0, 0, 1};
        int b1 = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            valid = '0; last = '0; randomize_payloads();
            valid[1] = (b1 < 6); last[1] = (b1 == 5);
            valid[2] = 1'b1;     last[2] = 1'b1;
            #1;
            n_checks++;
            if (push !== 1'b1 || psrc !== IW'(exp_src[c]) || locked !== exp_lck[c]) begin
                $display("FAIL burst_lock c%0d: push=%b src=%0d locked=%b, required push=1 src=%0d locked=%0d",
                         c, push, psrc, locked, exp_src[c], exp_lck[c]);
                n_fail++;
            end
            if (ready[1] === 1'b1) b1++;
        end
    endtask

    task automatic test_early_last();
        int exp_src [3] = '{0, 0, 3};
        bit exp_lck [3] = '{0, 1, 0};
        int b0 = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid = '0; last = '0; randomize_payloads();
            valid[0] = (b0 < 2); last[0] = (b0 == 1);
            valid[3] = 1'b1;     last[3] = 1'b1;
            #1;
            n_checks++;
            if (push !== 1'b1 || psrc !== IW'(exp_src[c]) || locked !== exp_lck[c]) begin
                $display("FAIL early_last c%0d: push=%b src=%0d locked=%b, required push=1 src=%0d locked=%0d",
                         c, push, psrc, locked, exp_src[c], exp_lck[c]);
                n_fail++;
            end
            if (ready[0] === 1'b1) b0++;
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        @(negedge clk);
        valid = 4'b0100; last = '0; full = 1'b0; randomize_payloads();
        #1;
        n_checks++;
        if (push !== 1'b1 || psrc !== 2'd2) begin
            $display("FAIL full_first: push=%b src=%0d, required 1 2", push, psrc);
            n_fail++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            valid = 4'b0101; last = '0; full = 1'b1; randomize_payloads();
            #1;
            n_checks++;
            if (push !== 1'b0 || ready !== 4'b0 || grant !== 4'b0100 || locked !== 1'b1) begin
                $display("FAIL full_hold c%0d: push=%b ready=%b grant=%b locked=%b, required 0 0000 0100 1",
                         c, push, ready, grant, locked);
                n_fail++;
            end
        end
        // Beats 2..4 of req2; the fourth forces rotation only if the count held while full.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            valid = 4'b0101; last = '0; full = 1'b0; randomize_payloads();
            #1;
            n_checks++;
            if (push !== 1'b1 || psrc !== 2'd2 || ready !== 4'b0100 || locked !== 1'b1) begin
                $display("FAIL full_resume c%0d: push=%b src=%0d ready=%b locked=%b, required 1 2 0100 1",
                         c, push, psrc, ready, locked);
                n_fail++;
            end
        end
        @(negedge clk);
        valid = 4'b0101; last = 4'b0001; randomize_payloads();
        #1;
        n_checks++;
        if (push !== 1'b1 || psrc !== 2'd0 || locked !== 1'b0) begin
            $display("FAIL full_rotate: push=%b src=%0d locked=%b, required 1 0 0", push, psrc, locked);
            n_fail++;
        end
    endtask

    task automatic test_flush_mid_burst();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            valid = 4'b0010; last = '0; randomize_payloads();
            #1;
            n_checks++;
            if (push !== 1'b1 || psrc !== 2'd1 || locked !== (c == 1)) begin
                $display("FAIL flush_prelock c%0d: push=%b src=%0d locked=%b, required 1 1 %0d",
                         c, push, psrc, locked, c);
                n_fail++;
            end
        end
        @(negedge clk);
        valid = 4'hF; last = 4'hF; flush = 1'b1; randomize_payloads();
        #1;
        n_checks++;
        if (fflush !== 1'b1 || push !== 1'b0 || ready !== 4'b0) begin
            $display("FAIL flush_cycle: flush_o=%b push=%b ready=%b, required 1 0 0000", fflush, push, ready);
            n_fail++;
        end
        @(negedge clk);
        flush = 1'b0; randomize_payloads();
        #1;
        n_checks++;
        if (locked !== 1'b0 || fflush !== 1'b0 || push !== 1'b1 || psrc !== 2'd2) begin
            $display("FAIL flush_after: locked=%b flush_o=%b push=%b src=%0d, required 0 0 1 2",
                     locked, fflush, push, psrc);
            n_fail++;
        end
    endtask

    // Reference: FIFO of depth 8 fed by the arbiter; model tracks the turn and any held burst.
    task automatic test_random(input int cycles);
        logic [IW+WW-1:0] q_act[$];
        logic [IW+WW-1:0] q_exp[$];
        logic [IW+WW-1:0] got, want;
        int ptr = 0, owner = -1, beats = 0;
        int win;
        bit acc, pop;
        logic [NR-1:0] exp_grant, one;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                valid[i] = ($urandom_range(0, 9) < 6);
                last[i]  = ($urandom_range(0, 9) < 4);
            end
            randomize_payloads();
            flush = ($urandom_range(0, 49) == 0);
            full  = (q_act.size() >= 8);
            #1;
            win = -1;
            if (owner >= 0) win = owner;
            else
                for (int k = 0; k < NR; k++)
                    if (win < 0 && valid[(ptr + k) % NR]) win = (ptr + k) % NR;
            one = 1;
            exp_grant = (win >= 0) ? (one << win) : '0;
            acc = (win >= 0) && valid[win] && !full && !flush;
            n_checks++;
            if (grant !== exp_grant || push !== acc || ready !== (acc ? exp_grant : 4'b0) ||
                locked !== (owner >= 0) || fflush !== flush ||
                (acc && (psrc !== IW'(win) || ppay !== payload[win*WW +: WW]))) begin
                $display("FAIL random c%0d: grant=%b push=%b ready=%b locked=%b src=%0d pay=%h, required grant=%b push=%b locked=%0d src=%0d",
                         c, grant, push, ready, locked, psrc, ppay, exp_grant, acc, owner >= 0, win);
                n_fail++;
            end
            pop = (q_act.size() > 0) && ($urandom_range(0, 1) == 1);
            if (flush) begin
                q_act.delete();
                q_exp.delete();
            end else begin
                if (pop) begin
                    got = q_act.pop_front();
                    n_checks++;
                    if (q_exp.size() == 0) begin
                        $display("FAIL fifo_pop c%0d: popped %h, required nothing", c, got);
                        n_fail++;
                    end else begin
                        want = q_exp.pop_front();
                        if (got !== want) begin
                            $display("FAIL fifo_pop c%0d: popped %h, required %h", c, got, want);
                            n_fail++;
                        end
                    end
                end
                if (push === 1'b1) q_act.push_back({psrc, ppay});
                if (acc) q_exp.push_back({IW'(win), payload[win*WW +: WW]});
            end
            if (flush) begin
                if (owner >= 0) ptr = (owner + 1) % NR;
                owner = -1;
                beats = 0;
            end else if (acc) begin
                beats++;
                if (last[win] || beats == MB) begin
                    owner = -1;
                    ptr   = (win + 1) % NR;
                    beats = 0;
                end else begin
                    owner = win;
                end
            end
        end
        n_checks++;
        if (q_act.size() != q_exp.size()) begin
            $display("FAIL fifo_level: occupancy %0d, required %0d", q_act.size(), q_exp.size());
            n_fail++;
        end
        @(negedge clk);
        valid = '0; flush = 1'b0; full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fair_rotation();
        test_burst_lock();
        test_early_last();
        test_full_backpressure();
        test_flush_mid_burst();
        test_random(20000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
